// File: rtl/fp_iter_sequencer.sv
// Control sequencer for the shared iterative FP divide/sqrt datapath.
// Accepts one operation at a time, runs ceil((NF+3)/RK) iterations for
// the requested format, then holds Done until the Memory stage stops stalling.
module fp_iter_sequencer #(
  parameter int unsigned RK    = 2,
  parameter int unsigned S_NF  = 23,
  parameter int unsigned D_NF  = 52,
  parameter int unsigned H_NF  = 10,
  parameter int unsigned Q_NF  = 112,
  parameter logic [3:0]  FMTEN = 4'b0011,
  parameter int unsigned CNTW  = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [1:0]      Fmt,
  input  logic            SpecialCaseE,
  input  logic            FlushE,
  input  logic            StallM,
  output logic            Ready,
  output logic            Busy,
  output logic            FirstIter,
  output logic            IterEn,
  output logic            LastIter,
  output logic            Done,
  output logic            FmtErr,
  output logic [CNTW-1:0] IterLeft
);

  // Iterations per format: enough RK-bit steps to cover fraction + 3 extra bits.
  localparam int unsigned NS = (S_NF + 3 + RK - 1) / RK;
  localparam int unsigned ND = (D_NF + 3 + RK - 1) / RK;
  localparam int unsigned NH = (H_NF + 3 + RK - 1) / RK;
  localparam int unsigned NQ = (Q_NF + 3 + RK - 1) / RK;

  // The counter must be able to hold the longest (quad) iteration count.
  generate
    if (NQ > (2 ** CNTW) - 1) begin : g_cntw_check
      $error("CNTW too narrow for the quad iteration count");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            fmterr_q, fmterr_d;
  logic [CNTW-1:0] niter;

  // Iteration count for the format presented at accept time.
  always_comb begin
    niter = CNTW'(NS);
    unique case (Fmt)
      2'd0: niter = CNTW'(NS);
      2'd1: niter = CNTW'(ND);
      2'd2: niter = CNTW'(NH);
      2'd3: niter = CNTW'(NQ);
      default: niter = CNTW'(NS);
    endcase
  end

  // Next-state logic; a flush overrides everything and returns to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    fmterr_d = fmterr_q;
    unique case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          if (!FMTEN[Fmt]) begin
            state_d  = DONE;
            fmterr_d = 1'b1;
          end else if (SpecialCaseE) begin
            state_d  = DONE;
            fmterr_d = 1'b0;
          end else begin
            state_d  = BUSY;
            cnt_d    = niter - CNTW'(1);
            first_d  = 1'b1;
            fmterr_d = 1'b0;
          end
        end
      end
      BUSY: begin
        first_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        if (!StallM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (FlushE) begin
      state_d = IDLE;
      first_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      fmterr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      fmterr_q <= fmterr_d;
    end
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    Ready     = (state_q == IDLE);
    Busy      = (state_q == BUSY);
    IterEn    = (state_q == BUSY);
    FirstIter = (state_q == BUSY) && first_q;
    LastIter  = (state_q == BUSY) && (cnt_q == '0);
    Done      = (state_q == DONE);
    FmtErr    = (state_q == DONE) && fmterr_q;
    IterLeft  = (state_q == BUSY) ? cnt_q : '0;
  end

endmodule
